// File: rtl/keccak_pkg.sv
// Shared definitions for the keccak byte packer: word geometry, FSM states, lane placement.
package keccak_pkg;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned WORD_W     = 64;
    localparam int unsigned LANE_W     = $clog2(WORD_BYTES);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SEND,
        ST_SEND_LAST,
        ST_DONE
    } state_t;

    // Bit offset of a lane's LSB; lane 0 lands in the top byte.
    function automatic logic [5:0] lane_offset(input logic [LANE_W-1:0] lane);
        return {~lane, 3'b000};
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs one byte-stream message into 64-bit keccak core words with last/byte_num marking.
module keccak_byte_packer
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [WORD_W-1:0] k_in,
    output logic              k_in_ready,
    output logic              k_is_last,
    output logic [LANE_W-1:0] k_byte_num,
    input  logic              k_buffer_full
);

    state_t              state;
    logic [LANE_W-1:0]   lane;
    logic [WORD_W-1:0]   acc;
    logic [WORD_W-1:0]   acc_written;
    logic                pend_empty;
    logic                byte_take;
    logic                word_take;

    assign byte_take = s_valid && s_ready;
    assign word_take = k_in_ready && !k_buffer_full;

    // Unwritten lanes of acc are always zero, so OR-ing places the byte.
    always_comb begin
        acc_written = acc | (WORD_W'(s_data) << lane_offset(lane));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FILL;
            lane       <= '0;
            acc        <= '0;
            pend_empty <= 1'b0;
            s_ready    <= 1'b0;
            k_in       <= '0;
            k_in_ready <= 1'b0;
            k_is_last  <= 1'b0;
            k_byte_num <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    s_ready <= 1'b1;
                    if (byte_take) begin
                        if (lane == LAST_LANE || s_last) begin
                            s_ready    <= 1'b0;
                            k_in       <= acc_written;
                            k_in_ready <= 1'b1;
                            acc        <= '0;
                            lane       <= '0;
                            if (lane == LAST_LANE) begin
                                // A full final word still needs an empty last word after it.
                                state      <= ST_SEND;
                                pend_empty <= s_last;
                            end else begin
                                state      <= ST_SEND_LAST;
                                k_is_last  <= 1'b1;
                                k_byte_num <= lane + LANE_W'(1);
                            end
                        end else begin
                            acc  <= acc_written;
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end

                ST_SEND: begin
                    if (word_take) begin
                        if (pend_empty) begin
                            state      <= ST_SEND_LAST;
                            pend_empty <= 1'b0;
                            k_in       <= '0;
                            k_is_last  <= 1'b1;
                            k_byte_num <= '0;
                        end else begin
                            state      <= ST_FILL;
                            lane       <= '0;
                            acc        <= '0;
                            s_ready    <= 1'b1;
                            k_in       <= '0;
                            k_in_ready <= 1'b0;
                        end
                    end
                end

                ST_SEND_LAST: begin
                    if (word_take) begin
                        state      <= ST_DONE;
                        k_in       <= '0;
                        k_in_ready <= 1'b0;
                        k_is_last  <= 1'b0;
                        k_byte_num <= '0;
                    end
                end

                default: begin
                    // Hold all outputs low until the next reset.
                    s_ready    <= 1'b0;
                    k_in       <= '0;
                    k_in_ready <= 1'b0;
                    k_is_last  <= 1'b0;
                    k_byte_num <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer with a scoreboard of expected core words.
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        k_buffer_full;

    typedef struct packed {
        logic [63:0] word;
        logic        last;
        logic [2:0]  bn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    keccak_byte_packer dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .k_in         (k_in),
        .k_in_ready   (k_in_ready),
        .k_is_last    (k_is_last),
        .k_byte_num   (k_byte_num),
        .k_buffer_full(k_buffer_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // Scoreboard side: every word handed to the core must match the queue head.
    always @(negedge clk) begin
        if (k_in_ready && !k_buffer_full) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", k_in, 64'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word", k_in, e.word);
                check("is_last", 64'(k_is_last), 64'(e.last));
                check("byte_num", 64'(k_byte_num), 64'(e.bn));
            end
        end
        if (!reset) begin
            if (k_is_last) check("last_needs_ready", 64'(k_in_ready), 64'd1);
            if (!k_is_last) check("byte_num_zero", 64'(k_byte_num), 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            step();
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_k_in_ready", 64'(k_in_ready), 64'd0);
            check("rst_k_in", k_in, 64'd0);
            check("rst_k_is_last", 64'(k_is_last), 64'd0);
        end
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last, input bit gappy);
        bit taken;
        int n;
        if (gappy && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            step();
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        taken   = 1'b0;
        n       = 0;
        while (!taken && n < 200) begin
            @(negedge clk);
            taken = s_ready;
            step();
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!taken) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic push_exp(input logic [63:0] w, input logic l, input logic [2:0] b);
        exp_t e;
        e.word = w;
        e.last = l;
        e.bn   = b;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [63:0] held;
        reset         = 1'b1;
        s_data        = '0;
        s_valid       = 1'b0;
        s_last        = 1'b0;
        k_buffer_full = 1'b0;

        // Test 1: three-byte message
        do_reset(2);
        push_exp(64'h6162630000000000, 1'b1, 3'd3);
        send_byte(8'h61, 1'b0, 1'b0);
        send_byte(8'h62, 1'b0, 1'b0);
        send_byte(8'h63, 1'b1, 1'b0);
        drain();
        step();
        check("done_s_ready", 64'(s_ready), 64'd0);
        check("done_k_in_ready", 64'(k_in_ready), 64'd0);

        // Test 2: exactly eight bytes -> extra empty last word
        do_reset(1);
        push_exp(64'h0102030405060708, 1'b0, 3'd0);
        push_exp(64'h0, 1'b1, 3'd0);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8, 1'b0);
        drain();

        // Test 3: ten bytes
        do_reset(1);
        push_exp(64'h0001020304050607, 1'b0, 3'd0);
        push_exp(64'h0809000000000000, 1'b1, 3'd2);
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9, 1'b0);
        drain();

        // Test 4: back-pressure during SEND
        do_reset(1);
        k_buffer_full = 1'b1;
        push_exp(64'h1112131415161718, 1'b0, 3'd0);
        push_exp(64'h0, 1'b1, 3'd0);
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), i == 7, 1'b0);
        check("stall_word_presented", 64'(k_in_ready), 64'd1);
        held = k_in;
        check("stall_word_value", held, 64'h1112131415161718);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_k_in_hold", k_in, held);
            check("stall_k_in_ready", 64'(k_in_ready), 64'd1);
            check("stall_s_ready", 64'(s_ready), 64'd0);
        end
        k_buffer_full = 1'b0;
        step();
        check("stall_released_next", 64'(exp_q.size()), 64'd1);
        drain();

        // Test 5: reset mid-message, then a fresh message
        do_reset(1);
        for (int i = 0; i < 4; i++) send_byte(8'hAA + 8'(i), 1'b0, 1'b0);
        do_reset(2);
        push_exp(64'h0102030000000000, 1'b1, 3'd3);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0);
        drain();

        // Test 6: gappy valid, then stray bytes after DONE
        do_reset(1);
        push_exp(64'h0001020304050607, 1'b0, 3'd0);
        push_exp(64'h0809000000000000, 1'b1, 3'd2);
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9, 1'b1);
        drain();
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_done_s_ready", 64'(s_ready), 64'd0);
            check("post_done_k_in_ready", 64'(k_in_ready), 64'd0);
            step();
            s_data = 8'(s_data + 8'd1);
        end
        s_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
